// File: rtl/spi_cfg_sequencer.sv
// SPI configuration sequencer: walks the init table after reset, then serves
// host transactions, owning the SPI engine's four-phase GO/DONE handshake.
module spi_cfg_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int SYNC_CYCLES = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic              CLK_1MHZ,
    input  logic              RESET_N,
    input  logic              INIT_START,
    output logic [ADDR_W-1:0] TBL_ADDR,
    input  logic [33:0]       TBL_DATA,
    input  logic              HOST_REQ,
    input  logic [1:0]        HOST_SEL,
    input  logic [31:0]       HOST_DATA,
    output logic              HOST_DONE,
    output logic [31:0]       HOST_RDATA,
    output logic              SPI_GO,
    input  logic              SPI_DONE,
    output logic [31:0]       SPI_IN,
    input  logic [31:0]       SPI_OUT,
    output logic [1:0]        SPI_SEL,
    output logic              SYNC,
    output logic              INIT_BUSY,
    output logic              INIT_DONE,
    output logic              ERR
);

    typedef enum logic [3:0] {
        IDLE, I_LOAD, I_GO, I_WAIT_DONE, I_WAIT_REL, I_GAP, SYNC_P,
        H_GO, H_WAIT_DONE, H_WAIT_REL, H_GAP
    } state_t;

    localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]        SYNC_LAST = 8'(SYNC_CYCLES - 1);
    localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                init_pend_q, init_pend_d;
    logic                armed_q, armed_d;
    logic [ADDR_W-1:0]   tbl_addr_q, tbl_addr_d;
    logic                spi_go_q, spi_go_d;
    logic [31:0]         spi_in_q, spi_in_d;
    logic [1:0]          spi_sel_q, spi_sel_d;
    logic                sync_q, sync_d;
    logic                host_done_q, host_done_d;
    logic [31:0]         host_rdata_q, host_rdata_d;
    logic                init_busy_q, init_busy_d;
    logic                init_done_q, init_done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d      = state_q;
        init_pend_d  = init_pend_q;
        armed_d      = armed_q;
        tbl_addr_d   = tbl_addr_q;
        spi_go_d     = spi_go_q;
        spi_in_d     = spi_in_q;
        spi_sel_d    = spi_sel_q;
        sync_d       = sync_q;
        host_done_d  = 1'b0;
        host_rdata_d = host_rdata_q;
        init_busy_d  = init_busy_q;
        init_done_d  = init_done_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (init_pend_q || INIT_START) begin
                    state_d     = I_LOAD;
                    init_pend_d = 1'b0;
                    init_busy_d = 1'b1;
                    init_done_d = 1'b0;
                    err_d       = 1'b0;
                    tbl_addr_d  = '0;
                end else if (HOST_REQ && armed_q) begin
                    state_d   = H_GO;
                    spi_sel_d = HOST_SEL;
                    spi_in_d  = HOST_DATA;
                end
            end
            I_LOAD: begin
                if (TBL_DATA[33:32] == 2'b11) begin
                    state_d = SYNC_P;
                    sync_d  = 1'b1;
                end else begin
                    state_d   = I_GO;
                    spi_sel_d = TBL_DATA[33:32];
                    spi_in_d  = TBL_DATA[31:0];
                end
            end
            I_GO, H_GO: begin
                spi_go_d = 1'b1;
                state_d  = (state_q == I_GO) ? I_WAIT_DONE : H_WAIT_DONE;
            end
            I_WAIT_DONE, H_WAIT_DONE: begin
                // A timeout is handled as a DONE that returns all-ones data
                if (SPI_DONE || cnt_q == TMO_LAST) begin
                    spi_go_d = 1'b0;
                    state_d  = (state_q == I_WAIT_DONE) ? I_WAIT_REL : H_WAIT_REL;
                    if (!SPI_DONE) err_d = 1'b1;
                    if (state_q == H_WAIT_DONE) begin
                        host_done_d  = 1'b1;
                        host_rdata_d = SPI_DONE ? SPI_OUT : 32'hFFFF_FFFF;
                    end
                end
            end
            I_WAIT_REL, H_WAIT_REL: begin
                if (!SPI_DONE || cnt_q == TMO_LAST) begin
                    state_d = (state_q == I_WAIT_REL) ? I_GAP : H_GAP;
                    if (SPI_DONE) err_d = 1'b1;
                end
            end
            I_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (tbl_addr_q == ADDR_LAST) begin
                        state_d = SYNC_P;
                        sync_d  = 1'b1;
                    end else begin
                        state_d    = I_LOAD;
                        tbl_addr_d = tbl_addr_q + 1'b1;
                    end
                end
            end
            H_GAP: begin
                if (cnt_q == GAP_LAST) state_d = IDLE;
            end
            SYNC_P: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d     = IDLE;
                    sync_d      = 1'b0;
                    init_busy_d = 1'b0;
                    init_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Init requests during a host transaction wait; during init they are dropped
        if ((state_q inside {H_GO, H_WAIT_DONE, H_WAIT_REL, H_GAP}) && INIT_START)
            init_pend_d = 1'b1;

        if (host_done_d)
            armed_d = 1'b0;
        else if (!HOST_REQ)
            armed_d = 1'b1;

        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge CLK_1MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            init_pend_q  <= 1'b1;
            armed_q      <= 1'b1;
            tbl_addr_q   <= '0;
            spi_go_q     <= 1'b0;
            spi_in_q     <= 32'd0;
            spi_sel_q    <= 2'd0;
            sync_q       <= 1'b0;
            host_done_q  <= 1'b0;
            host_rdata_q <= 32'd0;
            init_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_pend_q  <= init_pend_d;
            armed_q      <= armed_d;
            tbl_addr_q   <= tbl_addr_d;
            spi_go_q     <= spi_go_d;
            spi_in_q     <= spi_in_d;
            spi_sel_q    <= spi_sel_d;
            sync_q       <= sync_d;
            host_done_q  <= host_done_d;
            host_rdata_q <= host_rdata_d;
            init_busy_q  <= init_busy_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
        end
    end

    assign TBL_ADDR   = tbl_addr_q;
    assign SPI_GO     = spi_go_q;
    assign SPI_IN     = spi_in_q;
    assign SPI_SEL    = spi_sel_q;
    assign SYNC       = sync_q;
    assign HOST_DONE  = host_done_q;
    assign HOST_RDATA = host_rdata_q;
    assign INIT_BUSY  = init_busy_q;
    assign INIT_DONE  = init_done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer with an SPI engine model and scoreboards
// for the expected SPI words and host read-back data.
module tb_spi_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic [3:0]  tbl_addr;
    logic [33:0] tbl_data;
    logic        host_req = 1'b0;
    logic [1:0]  host_sel = 2'd0;
    logic [31:0] host_data = 32'd0;
    logic        host_done;
    logic [31:0] host_rdata;
    logic        spi_go;
    logic        spi_done = 1'b0;
    logic [31:0] spi_in;
    logic [31:0] spi_out = 32'd0;
    logic [1:0]  spi_sel;
    logic        sync;
    logic        init_busy;
    logic        init_done;
    logic        err;

    logic [33:0] tbl [16];
    assign tbl_data = tbl[tbl_addr];

    always #5 clk = ~clk;

    spi_cfg_sequencer dut (
        .CLK_1MHZ  (clk),
        .RESET_N   (rst_n),
        .INIT_START(init_start),
        .TBL_ADDR  (tbl_addr),
        .TBL_DATA  (tbl_data),
        .HOST_REQ  (host_req),
        .HOST_SEL  (host_sel),
        .HOST_DATA (host_data),
        .HOST_DONE (host_done),
        .HOST_RDATA(host_rdata),
        .SPI_GO    (spi_go),
        .SPI_DONE  (spi_done),
        .SPI_IN    (spi_in),
        .SPI_OUT   (spi_out),
        .SPI_SEL   (spi_sel),
        .SYNC      (sync),
        .INIT_BUSY (init_busy),
        .INIT_DONE (init_done),
        .ERR       (err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_hs = 0;
    int n_hdone = 0;
    logic [33:0] exp_q [$];
    logic [31:0] host_q [$];

    int          e_lat = 2;
    bit          e_hang = 1'b0;
    logic [31:0] e_rdata = 32'd0;
    int          e_st = 0;
    int          e_cnt = 0;
    logic [33:0] e_word = 34'd0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI engine model: answers GO after e_lat cycles, releases DONE after GO drops
    always @(negedge clk) begin
        if (!rst_n) begin
            e_st = 0;
            spi_done = 1'b0;
        end else begin
            case (e_st)
                0: if (spi_go) begin
                    n_hs++;
                    e_word = {spi_sel, spi_in};
                    check("go_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) check("spi_word", 64'(e_word), 64'(exp_q.pop_front()));
                    e_cnt = e_lat;
                    e_st = e_hang ? 3 : 1;
                end
                1: begin
                    check("go_held", 64'(spi_go), 64'd1);
                    check("word_stable", 64'({spi_sel, spi_in}), 64'(e_word));
                    if (e_cnt == 0) begin
                        spi_done = 1'b1;
                        spi_out = e_rdata;
                        e_st = 2;
                    end else begin
                        e_cnt--;
                    end
                end
                2: begin
                    check("word_stable_done", 64'({spi_sel, spi_in}), 64'(e_word));
                    if (!spi_go) begin
                        spi_done = 1'b0;
                        e_st = 0;
                    end
                end
                default: if (!spi_go) e_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && host_done) begin
            n_hdone++;
            check("host_q_nonempty", 64'(host_q.size() != 0), 64'd1);
            if (host_q.size() != 0) check("host_rdata", 64'(host_rdata), 64'(host_q.pop_front()));
            check("go_drop_with_done", 64'(spi_go), 64'd0);
        end
    end

    task automatic load_tbl3();
        for (int i = 0; i < 16; i++) tbl[i] = {2'b11, 32'd0};
        tbl[0] = {2'd0, 32'hA5A5_0001};
        tbl[1] = {2'd1, 32'hA5A5_0002};
        tbl[2] = {2'd2, 32'hA5A5_0003};
        for (int i = 0; i < 3; i++) exp_q.push_back(tbl[i]);
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_go"},    64'(spi_go),     64'd0);
        check({tag, "_in"},    64'(spi_in),     64'd0);
        check({tag, "_sel"},   64'(spi_sel),    64'd0);
        check({tag, "_addr"},  64'(tbl_addr),   64'd0);
        check({tag, "_sync"},  64'(sync),       64'd0);
        check({tag, "_hdone"}, 64'(host_done),  64'd0);
        check({tag, "_rdata"}, 64'(host_rdata), 64'd0);
        check({tag, "_busy"},  64'(init_busy),  64'd0);
        check({tag, "_idone"}, 64'(init_done),  64'd0);
        check({tag, "_err"},   64'(err),        64'd0);
    endtask

    task automatic wait_init_done(string tag);
        for (int i = 0; i < 2000; i++) begin
            if (init_done) break;
            @(negedge clk);
        end
        check(tag, 64'(init_done), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hs0;
        int hd0;

        // Reset values, then 3-entry table with end marker
        load_tbl3();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_first_edge", 64'(init_busy), 64'd1);
        check("go_not_yet", 64'(spi_go), 64'd0);
        @(negedge clk);
        check("go_not_yet2", 64'(spi_go), 64'd0);
        @(negedge clk);
        check("go_third_edge", 64'(spi_go), 64'd1);
        for (int i = 0; i < 500; i++) begin
            if (sync) break;
            @(negedge clk);
        end
        check("sync_rise", 64'(sync), 64'd1);
        check("idone_low_in_sync", 64'(init_done), 64'd0);
        w = 0;
        while (sync && w < 50) begin
            w++;
            @(negedge clk);
        end
        check("sync_width", 64'(w), 64'd8);
        check("idone_with_sync_fall", 64'(init_done), 64'd1);
        check("busy_clear", 64'(init_busy), 64'd0);
        check("err_clear", 64'(err), 64'd0);
        check("init3_handshakes", 64'(n_hs), 64'd3);
        check("init3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full 16-entry table, no end marker
        for (int i = 0; i < 16; i++) begin
            tbl[i] = {2'(i % 3), 32'h5A00_0000 + 32'(i)};
            exp_q.push_back(tbl[i]);
        end
        hs0 = n_hs;
        e_lat = 1;
        pulse_init();
        check("init16_busy", 64'(init_busy), 64'd1);
        check("init16_idone_clr", 64'(init_done), 64'd0);
        for (int i = 0; i < 1000; i++) begin
            if (sync) break;
            @(negedge clk);
        end
        check("init16_sync", 64'(sync), 64'd1);
        check("init16_addr_stop", 64'(tbl_addr), 64'd15);
        check("init16_handshakes", 64'(n_hs - hs0), 64'd16);
        check("init16_queue_empty", 64'(exp_q.size()), 64'd0);
        wait_init_done("init16_done");
        check("init16_addr_nowrap", 64'(tbl_addr), 64'd15);

        // Host transaction with held request
        hs0 = n_hs;
        hd0 = n_hdone;
        e_rdata = 32'hCAFE_F00D;
        host_sel = 2'd2;
        host_data = 32'h1234_5678;
        host_req = 1'b1;
        exp_q.push_back({2'd2, 32'h1234_5678});
        host_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        check("host_go_not_yet", 64'(spi_go), 64'd0);
        @(negedge clk);
        check("host_go_latency", 64'(spi_go), 64'd1);
        repeat (40) @(negedge clk);
        check("host_one_done", 64'(n_hdone - hd0), 64'd1);
        check("host_one_go", 64'(n_hs - hs0), 64'd1);
        check("host_rdata_hold", 64'(host_rdata), 64'hCAFE_F00D);
        host_req = 1'b0;
        repeat (2) @(negedge clk);

        // INIT_START mid host transaction
        e_lat = 3;
        e_rdata = 32'h1111_2222;
        host_sel = 2'd1;
        host_data = 32'h0BAD_BEEF;
        exp_q.push_back({2'd1, 32'h0BAD_BEEF});
        host_q.push_back(32'h1111_2222);
        load_tbl3();
        host_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (spi_go) break;
            @(negedge clk);
        end
        check("mid_host_go", 64'(spi_go), 64'd1);
        pulse_init();
        check("mid_init_deferred", 64'(init_busy), 64'd0);
        check("mid_idone_still", 64'(init_done), 64'd1);
        for (int i = 0; i < 50; i++) begin
            if (host_done) break;
            @(negedge clk);
        end
        check("mid_host_done", 64'(host_done), 64'd1);
        host_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (init_busy) break;
            @(negedge clk);
        end
        check("mid_init_started", 64'(init_busy), 64'd1);
        check("mid_idone_drop", 64'(init_done), 64'd0);
        wait_init_done("mid_idone_rerise");
        check("mid_queue_empty", 64'(exp_q.size()), 64'd0);

        // Host timeout: engine never answers
        e_hang = 1'b1;
        host_sel = 2'd0;
        host_data = 32'hDEAD_0000;
        exp_q.push_back({2'd0, 32'hDEAD_0000});
        host_q.push_back(32'hFFFF_FFFF);
        hd0 = n_hdone;
        host_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (spi_go) break;
            @(negedge clk);
        end
        check("tmo_go_rise", 64'(spi_go), 64'd1);
        w = 0;
        while (spi_go && w < 400) begin
            w++;
            @(negedge clk);
        end
        check("tmo_go_width", 64'(w), 64'd255);
        check("tmo_err", 64'(err), 64'd1);
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        check("tmo_host_done", 64'(n_hdone - hd0), 64'd1);
        e_hang = 1'b0;
        repeat (8) @(negedge clk);
        check("tmo_err_sticky", 64'(err), 64'd1);
        load_tbl3();
        pulse_init();
        check("tmo_err_cleared", 64'(err), 64'd0);
        wait_init_done("tmo_reinit_done");
        check("tmo_err_after_init", 64'(err), 64'd0);

        // Reset asserted while SPI_GO is high
        e_lat = 20;
        load_tbl3();
        pulse_init();
        for (int i = 0; i < 10; i++) begin
            if (spi_go) break;
            @(negedge clk);
        end
        check("rst_go_high", 64'(spi_go), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_q.delete();
        repeat (2) @(negedge clk);
        e_lat = 1;
        hs0 = n_hs;
        load_tbl3();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy_again", 64'(init_busy), 64'd1);
        check("rst_addr_zero", 64'(tbl_addr), 64'd0);
        wait_init_done("rst_init_done");
        check("rst_handshakes", 64'(n_hs - hs0), 64'd3);
        check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
        check("host_queue_empty", 64'(host_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cfg_sequencer.md
# spi_cfg_sequencer

Controller for the shared SPI engine that programs the three jitter-cleaner chips. It owns the SPI engine's GO/DONE handshake and slave select, and arbitrates between two requesters. The first is an autonomous init sequencer that walks an external register table after reset, then pulses SYNC. The second is the Wishbone register-file host path. It sits between the Wishbone slave and the SPI engine/mux, clocked by the 1 MHz SPI clock.

## Interface
- ADDR_W, 4, init table address width; table depth 2^ADDR_W entries
- GAP_CYCLES, 4, idle cycles between consecutive SPI transactions (min 1)
- SYNC_CYCLES, 8, width of SYNC pulse after init completes (min 1)
- TIMEOUT, 255, max cycles waiting for each SPI_DONE edge before abort (8-bit counter)

Ports:
- CLK_1MHZ  in  1  sole clock
- RESET_N  in  1  asynchronous, active-low reset
- INIT_START  in  1  one-cycle pulse: rerun the init table
- TBL_ADDR  out  ADDR_W  init table read address
- TBL_DATA  in  34  {sel[1:0], word[31:0]}, combinational read of TBL_ADDR; sel=2'b11 is the end marker
- HOST_REQ  in  1  host transaction request, level, synchronous to CLK_1MHZ
- HOST_SEL  in  2  host target chip (0..2)
- HOST_DATA  in  32  host SPI word
- HOST_DONE  out  1  one-cycle completion pulse
- HOST_RDATA  out  32  SPI read-back word of the last host transaction
- SPI_GO  out  1  start request to SPI engine
- SPI_DONE  in  1  SPI engine completion
- SPI_IN  out  32  word to shift out
- SPI_OUT  in  32  word shifted in
- SPI_SEL  out  2  slave select to SPI mux
- SYNC  out  1  active-high sync pulse (inverted at top level)
- INIT_BUSY  out  1  init sequence in progress
- INIT_DONE  out  1  init completed since last reset/INIT_START
- ERR  out  1  sticky: an SPI handshake timed out

## Operation
- SPI handshake is four-phase:
  - SPI_GO rises with SPI_IN/SPI_SEL stable.
  - SPI_GO held until SPI_DONE=1 is sampled; SPI_GO then drops.
  - The block waits for SPI_DONE=0 before the GAP state.
  - SPI_IN/SPI_SEL do not change from GO rise until DONE falls.
- States: IDLE, I_LOAD, I_GO, I_WAIT_DONE, I_WAIT_REL, I_GAP, SYNC_P, H_GO, H_WAIT_DONE, H_WAIT_REL, H_GAP.
- Init:
  - Entered on reset release or a pending INIT_START. Clears INIT_DONE and ERR, sets INIT_BUSY, sets TBL_ADDR=0.
  - I_LOAD registers TBL_DATA into SPI_SEL/SPI_IN. If sel=2'b11, go to SYNC_P instead.
  - After I_GAP, TBL_ADDR increments. If TBL_ADDR was 2^ADDR_W-1, go to SYNC_P (no wrap); else go to I_LOAD.
  - SYNC_P: SYNC=1 for SYNC_CYCLES cycles. Then INIT_BUSY=0, INIT_DONE=1, IDLE.
- Host:
  - Accepted only in IDLE, when HOST_REQ=1 and the host is armed.
  - HOST_SEL/HOST_DATA are registered into SPI_SEL/SPI_IN.
  - HOST_RDATA captures SPI_OUT on the edge where SPI_DONE=1 is sampled. HOST_DONE pulses that same edge.
  - The host is disarmed after HOST_DONE and re-armed when HOST_REQ is sampled low. A held HOST_REQ never triggers a second transaction.
- Arbitration:
  - Init has priority. INIT_START arriving mid-host-transaction is latched as pending and starts after H_GAP.
  - INIT_START during init restarts nothing and is dropped.
  - INIT_START and HOST_REQ together in IDLE: init wins; host waits.
- Timeout:
  - An 8-bit counter runs in every WAIT state and resets on state entry.
  - Reaching TIMEOUT: drop SPI_GO, set ERR, proceed as if DONE/release occurred.
  - A host timeout still pulses HOST_DONE, with HOST_RDATA=32'hFFFF_FFFF.
- RESET_N low mid-transaction: all state and outputs return to reset values immediately. Init reruns after release.

## Timing
- Reset values: SPI_GO=0, SPI_IN=0, SPI_SEL=0, TBL_ADDR=0, SYNC=0, HOST_DONE=0, HOST_RDATA=0, INIT_BUSY=0, INIT_DONE=0, ERR=0. State=IDLE with init pending.
- INIT_BUSY=1 on the first edge after RESET_N release; SPI_GO=1 two edges after (I_LOAD, I_GO).
- Host latency: HOST_REQ sampled in IDLE -> SPI_GO=1 one cycle later.
- DONE to GO drop: 1 cycle. HOST_DONE coincides with the GO drop.
- Per-transaction overhead besides the SPI engine: 1 (load) + 1 (GO) + 1 (release detect) + GAP_CYCLES.
- SYNC asserts the cycle after the last I_GAP (or end marker load) and lasts exactly SYNC_CYCLES.
- INIT_DONE rises the same edge SYNC falls.

## Test plan
- Reset release, table of 3 entries {0,A5A5_0001},{1,A5A5_0002},{2,A5A5_0003} then sel=3 -> three GO/DONE handshakes with the matching SPI_SEL/SPI_IN, SYNC high 8 cycles, INIT_DONE=1, ERR=0.
- Full 16-entry table with no end marker -> 16 transactions, TBL_ADDR stops at 15, no wrap, then SYNC.
- After init, HOST_REQ=1 with sel=2, data=1234_5678, SPI_OUT=CAFE_F00D -> SPI_GO one cycle later, HOST_DONE one pulse, HOST_RDATA=CAFE_F00D; held HOST_REQ gives no second GO.
- INIT_START mid-host-transaction -> host completes first; init starts after the gap; INIT_DONE drops then re-rises.
- SPI_DONE never asserted on a host request -> GO drops after 255 cycles, ERR=1, HOST_DONE pulses with RDATA=FFFF_FFFF; next INIT_START clears ERR.
- RESET_N asserted while SPI_GO=1 -> all outputs zero asynchronously; init restarts from TBL_ADDR=0 after release.
